rc4_ksa_shuffle: RTL and testbench
==================================

# rc4_ksa_shuffle

RC4 key-scheduling (shuffle) engine that permutes the 256-byte S memory after the init pass has written `s[k] = k`. For `i = 0..255` it computes `j = j + s[i] + key[i mod KEY_BYTES]` (mod 256) and swaps `s[i]` and `s[j]`. It drives the shuffle input group of the S-memory access multiplexer; the top level selects task 2'b10 while `busy` is high. When it finishes, the decode stage takes over the memory.

## Interface
- `KEY_BYTES`, default 3: secret key length in bytes, 1..32.
- `clk` input, 1 bit: system clock; all state changes on its rising edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: begin a shuffle pass; sampled only in IDLE.
- `secret_key` input, KEY_BYTES*8 bits: key; byte 0 is the most-significant byte. Latched on accepted `start`.
- `s_q` input, 8 bits: S-memory read data; corresponds to the `s_address` presented one cycle earlier.
- `s_address` output, 8 bits: S-memory address (registered).
- `s_data` output, 8 bits: S-memory write data (registered).
- `s_write_enable` output, 1 bit: write strobe (registered).
- `busy` output, 1 bit: high from the cycle after `start` is accepted until `done`, inclusive.
- `done` output, 1 bit: single-cycle pulse at the end of the pass.

## Operation
- Registers: `i` (8 bits), `j` (8 bits), `si` (8 bits), `sj` (8 bits), `key_r` (latched key), and a last-iteration flag.
- State sequence and per-state behaviour:
  - IDLE: all outputs 0. `start=1` latches the key, sets `i=0` and `j=0`, and moves to RD_SI.
  - RD_SI: `s_address=i`, `we=0`.
  - WT_SI: `s_address=i`. Captures `si <= s_q` at the end of the cycle.
  - CALC_J: `j <= j + si + key_r[i mod KEY_BYTES]`, truncated to 8 bits.
  - RD_SJ: `s_address=j`.
  - WT_SJ: captures `sj <= s_q`.
  - WR_I: `s_address=i`, `s_data=sj`, `we=1`.
  - WR_J: `s_address=j`, `s_data=si`, `we=1`.
  - Iteration end: if `i==255`, go to DONE. Otherwise `i <= i+1` and go to RD_SI.
  - DONE: `done=1` and `busy=1` for one cycle, then IDLE. `j` keeps its final value until the next start.
- Key index: `i mod KEY_BYTES` is held in a separate counter that wraps to 0 at KEY_BYTES-1. No divider is used.
- `i == j`: both writes go to the same address with equal data (`si == sj`), so memory is unchanged.
- `start` while busy is ignored. `start` held high through DONE re-triggers a new pass on the following IDLE cycle.
- `secret_key` changes during a pass have no effect on that pass.

## Timing
- Reset values (asynchronous): state IDLE; `i`, `j`, `si`, `sj` = 0; `s_address`, `s_data`, `s_write_enable`, `busy`, `done` = 0.
- Reset mid-pass aborts immediately with no further writes. S-memory contents are then partially shuffled; the top level must rerun init.
- Each iteration takes 7 cycles (RD_SI through WR_J).
- Full pass: `start` accepted at edge 0, `done` high in cycle 1793, i.e. 256×7 + 1.
- Only one write per cycle, and `we` is never high in read states.
- Read-data assumption: memory has a registered address and unregistered q, so one cycle of latency.

## Configuration
- `KSA_SKIP_SELF_SWAP_EN`
  - Defined: if the new `j` equals `i` in CALC_J, RD_SJ through WR_J are skipped and the FSM proceeds directly to the iteration end. That iteration takes 3 cycles and issues no writes.
  - Not defined: every iteration takes 7 cycles, including the self-swap writes.
  - Final memory contents are identical in both builds.

## Test plan
- Reset: assert `reset_n=0` mid-pass at iteration 10 → all outputs 0 in the same cycle; after release, state is IDLE and no `we` pulse occurs.
- First iteration: memory initialised to `s[k]=k`, `secret_key=24'h030201`, pulse `start`.
  - Iteration `i=0` → `j=3`, writes `s[0]=3` then `s[3]=0`.
  - Iteration `i=1` → `j=6`, writes `s[1]=6` then `s[6]=1`.
- Full pass, macro not defined: same key → `done` pulses exactly 1793 cycles after start. Final S matches a software RC4 KSA model, and the result is a permutation of 0..255.
- Self-swap: `secret_key=24'h000000` → at `i=0`, `j=0`.
  - Without the macro: two writes of 0 to address 0.
  - With `KSA_SKIP_SELF_SWAP_EN`: no writes at `i=0`, and the pass is 4 cycles shorter for that iteration.
  - Final S is identical in both builds.
- Start handling: `start` pulsed during busy → ignored, `done` count unchanged. `start` held high → a second pass begins one cycle after `done`.
- KEY_BYTES=1, key 8'hFF: key index always 0, and the final S matches the reference model.

Source files
------------

// File: rtl/rc4_ksa_shuffle.sv
// RC4 key-scheduling shuffle engine: permutes the 256-byte S memory with the latched key.
// Optional build macro KSA_SKIP_SELF_SWAP_EN skips the read/write steps when j == i.
module rc4_ksa_shuffle #(
  parameter int unsigned KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [KEY_BYTES*8-1:0] secret_key,
  input  logic [7:0]             s_q,
  output logic [7:0]             s_address,
  output logic [7:0]             s_data,
  output logic                   s_write_enable,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned KIW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KIW-1:0] KI_LAST = KIW'(KEY_BYTES - 1);

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_RD_SI  = 4'd1;
  localparam logic [3:0] ST_WT_SI  = 4'd2;
  localparam logic [3:0] ST_CALC_J = 4'd3;
  localparam logic [3:0] ST_RD_SJ  = 4'd4;
  localparam logic [3:0] ST_WT_SJ  = 4'd5;
  localparam logic [3:0] ST_WR_I   = 4'd6;
  localparam logic [3:0] ST_WR_J   = 4'd7;
  localparam logic [3:0] ST_DONE   = 4'd8;

  logic [3:0]                  state, state_n;
  logic [7:0]                  i, i_n, j, j_n, si, si_n, sj, sj_n;
  logic [KEY_BYTES-1:0][7:0]   key_r, key_n;
  logic [KIW-1:0]              kidx, kidx_n;
  logic                        last, last_n;
  logic                        iter_end;
  logic [7:0]                  key_byte;
  logic [7:0]                  addr_n, data_n;
  logic                        we_n, busy_n, done_n;

  // Byte 0 of the key sits in the most-significant position.
  assign key_byte = key_r[KI_LAST - kidx];

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_n  = state;
    i_n      = i;
    j_n      = j;
    si_n     = si;
    sj_n     = sj;
    key_n    = key_r;
    kidx_n   = kidx;
    last_n   = last;
    iter_end = 1'b0;
    addr_n   = 8'd0;
    data_n   = 8'd0;
    we_n     = 1'b0;
    busy_n   = 1'b0;
    done_n   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          key_n   = secret_key;
          i_n     = 8'd0;
          j_n     = 8'd0;
          kidx_n  = '0;
          last_n  = 1'b0;
          state_n = ST_RD_SI;
        end
      end
      ST_RD_SI:  state_n = ST_WT_SI;
      ST_WT_SI: begin
        si_n    = s_q;
        state_n = ST_CALC_J;
      end
      ST_CALC_J: begin
        j_n     = j + si + key_byte;
        state_n = ST_RD_SJ;
`ifdef KSA_SKIP_SELF_SWAP_EN
        if (j_n == i) iter_end = 1'b1;
`endif
      end
      ST_RD_SJ:  state_n = ST_WT_SJ;
      ST_WT_SJ: begin
        sj_n    = s_q;
        state_n = ST_WR_I;
      end
      ST_WR_I:   state_n = ST_WR_J;
      ST_WR_J:   iter_end = 1'b1;
      ST_DONE:   state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase

    // Advance to the next index, or finish after i == 255.
    if (iter_end) begin
      if (last) begin
        state_n = ST_DONE;
      end else begin
        i_n     = i + 8'd1;
        kidx_n  = (kidx == KI_LAST) ? '0 : kidx + KIW'(1);
        last_n  = (i == 8'd254);
        state_n = ST_RD_SI;
      end
    end

    // Outputs are registered, so decode them from the state being entered.
    case (state_n)
      ST_RD_SI, ST_WT_SI, ST_CALC_J: begin
        addr_n = i_n;
        busy_n = 1'b1;
      end
      ST_RD_SJ, ST_WT_SJ: begin
        addr_n = j_n;
        busy_n = 1'b1;
      end
      ST_WR_I: begin
        addr_n = i_n;
        data_n = sj_n;
        we_n   = 1'b1;
        busy_n = 1'b1;
      end
      ST_WR_J: begin
        addr_n = j_n;
        data_n = si_n;
        we_n   = 1'b1;
        busy_n = 1'b1;
      end
      ST_DONE: begin
        busy_n = 1'b1;
        done_n = 1'b1;
      end
      default: begin
        addr_n = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      i              <= 8'd0;
      j              <= 8'd0;
      si             <= 8'd0;
      sj             <= 8'd0;
      key_r          <= '0;
      kidx           <= '0;
      last           <= 1'b0;
      s_address      <= 8'd0;
      s_data         <= 8'd0;
      s_write_enable <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_n;
      i              <= i_n;
      j              <= j_n;
      si             <= si_n;
      sj             <= sj_n;
      key_r          <= key_n;
      kidx           <= kidx_n;
      last           <= last_n;
      s_address      <= addr_n;
      s_data         <= data_n;
      s_write_enable <= we_n;
      busy           <= busy_n;
      done           <= done_n;
    end
  end

endmodule

// File: tb/tb_rc4_ksa_shuffle.sv
// Bench for rc4_ksa_shuffle: random keys against a software RC4 KSA model, two key lengths.
// Honours KSA_SKIP_SELF_SWAP_EN when computing expected write traffic and pass length.
module tb_rc4_ksa_shuffle;

  typedef logic [7:0] sbox_t [256];

`ifdef KSA_SKIP_SELF_SWAP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [1:0]  start;
  logic [23:0] key0;
  logic [7:0]  key1;
  logic [7:0]  q [2];
  logic [7:0]  addr [2];
  logic [7:0]  data [2];
  logic [1:0]  we, busy, done;

  logic [7:0]  mem [2][256];
  logic [7:0]  addr_r [2];
  logic [1:0]  init_req;
  logic [15:0] wlog[$];
  logic [15:0] exp_log[$];

  int n_vec;
  int n_err;

  rc4_ksa_shuffle #(.KEY_BYTES(3)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .secret_key(key0), .s_q(q[0]),
    .s_address(addr[0]), .s_data(data[0]), .s_write_enable(we[0]), .busy(busy[0]), .done(done[0])
  );

  rc4_ksa_shuffle #(.KEY_BYTES(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .secret_key(key1), .s_q(q[1]),
    .s_address(addr[1]), .s_data(data[1]), .s_write_enable(we[1]), .busy(busy[1]), .done(done[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // S memories: registered address, unregistered read data, write log of both ports.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (init_req[u]) begin
        for (int k = 0; k < 256; k++) mem[u][k] <= 8'(k);
      end else if (we[u]) begin
        mem[u][addr[u]] <= data[u];
        wlog.push_back({addr[u], data[u]});
      end
      addr_r[u] <= addr[u];
    end
  end

  assign q[0] = mem[0][addr_r[0]];
  assign q[1] = mem[1][addr_r[1]];

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Plain software RC4 KSA; also lists the memory writes the engine should issue.
  task automatic ksa_model(input sbox_t s_in, input logic [255:0] key, input int kb,
                           output sbox_t s_out, output int n_self);
    sbox_t s;
    int jj;
    logic [7:0] t;
    s = s_in;
    jj = 0;
    n_self = 0;
    exp_log.delete();
    for (int ii = 0; ii < 256; ii++) begin
      jj = (jj + int'(s[ii]) + int'(key[(kb - 1 - (ii % kb)) * 8 +: 8])) % 256;
      if (jj == ii) n_self++;
      if (!(SKIP && jj == ii)) begin
        exp_log.push_back({8'(ii), s[jj]});
        exp_log.push_back({8'(jj), s[ii]});
      end
      t = s[ii]; s[ii] = s[jj]; s[jj] = t;
    end
    s_out = s;
  endtask

  task automatic do_init(input int u);
    init_req[u] = 1'b1;
    @(posedge clk); #1;
    init_req[u] = 1'b0;
  endtask

  task automatic run_pass(input int sel, input logic [255:0] key, input int kb,
                          input bit pre_started, input bit poke_start, input bit hold);
    sbox_t cur, exp_s;
    int n_self, cyc, bad, exp_lat;
    logic [255:0] seen;
    for (int k = 0; k < 256; k++) cur[k] = mem[sel][k];
    ksa_model(cur, key, kb, exp_s, n_self);
    wlog.delete();
    if (!pre_started) begin
      @(negedge clk);
      if (sel == 0) key0 = key[23:0]; else key1 = key[7:0];
      start[sel] = 1'b1;
      @(posedge clk); #1;
      if (!hold) start[sel] = 1'b0;
    end
    cyc = 1;
    check("busy_first", busy[sel], 1);
    while (!done[sel] && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 300) begin
        if (sel == 0) key0 = 24'($urandom); else key1 = 8'($urandom);
      end
      if (poke_start && cyc == 500) start[sel] = 1'b1;
      if (poke_start && cyc == 501) start[sel] = 1'b0;
    end
    exp_lat = 7 * 256 + 1 - (SKIP ? 4 * n_self : 0);
    check("done_latency", cyc, exp_lat);
    check("write_count", wlog.size(), exp_log.size());
    bad = 0;
    for (int k = 0; k < exp_log.size(); k++)
      if (k >= wlog.size() || wlog[k] !== exp_log[k]) bad++;
    check("write_seq", bad, 0);
    bad = 0;
    seen = '0;
    for (int k = 0; k < 256; k++) begin
      if (mem[sel][k] !== exp_s[k]) bad++;
      seen[mem[sel][k]] = 1'b1;
    end
    check("final_s", bad, 0);
    check("permutation", $countones(seen), 256);
    if (!hold) begin
      @(posedge clk); #1;
      check("done_pulse", done[sel], 0);
      check("busy_after", busy[sel], 0);
    end
  endtask

  initial begin
    int nd, nwe, nb, guard;
    logic [23:0] rk;
    n_vec = 0;
    n_err = 0;
    reset_n = 1'b0;
    start = 2'b00;
    key0 = '0;
    key1 = '0;
    init_req = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", addr[0], 0);
    check("rst_data", data[0], 0);
    check("rst_we", we[0], 0);
    check("rst_busy", busy[0], 0);
    check("rst_done", done[0], 0);
    check("rst_busy1", busy[1], 0);
    init_req = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;

    // First iterations with the reference key.
    run_pass(0, 256'h030201, 3, 1'b0, 1'b0, 1'b0);
    check("it0_wr_i", wlog[0], 16'h0003);
    check("it0_wr_j", wlog[1], 16'h0300);
    check("it1_wr_i", wlog[2], 16'h0106);
    check("it1_wr_j", wlog[3], 16'h0601);

    // All-zero key: i == j on the first two iterations.
    do_init(0);
    run_pass(0, 256'h0, 3, 1'b0, 1'b0, 1'b0);
    check("self_wr0", wlog[0], SKIP ? 16'h0203 : 16'h0000);
    check("self_wr1", wlog[1], SKIP ? 16'h0302 : 16'h0000);

    // Random keys; first one also gets a stray start while busy.
    for (int r = 0; r < 3; r++) begin
      do_init(0);
      run_pass(0, 256'($urandom & 32'h00FF_FFFF), 3, 1'b0, r == 0, 1'b0);
      nd = 0;
      repeat (5) begin
        @(posedge clk); #1;
        nd += int'(done[0]);
      end
      check("no_retrigger", nd, 0);
    end

    // Start held high: new pass right after the IDLE cycle following done.
    rk = 24'($urandom);
    run_pass(0, 256'(rk), 3, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("hold_idle_busy", busy[0], 0);
    check("hold_idle_done", done[0], 0);
    @(posedge clk); #1;
    start[0] = 1'b0;
    check("hold_restart", busy[0], 1);
    run_pass(0, 256'(key0), 3, 1'b1, 1'b0, 1'b0);

    // One-byte key engine.
    do_init(1);
    run_pass(1, 256'hFF, 1, 1'b0, 1'b0, 1'b0);
    do_init(1);
    run_pass(1, 256'($urandom & 32'hFF), 1, 1'b0, 1'b0, 1'b0);

    // Reset during iteration 10.
    do_init(0);
    wlog.delete();
    @(negedge clk);
    key0 = 24'h030201;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    guard = 0;
    while (wlog.size() < 20 && guard < 400) begin
      @(posedge clk); #1;
      guard++;
    end
    check("rst_reach_it10", wlog.size(), 20);
    #3;
    reset_n = 1'b0;
    #1;
    check("midrst_addr", addr[0], 0);
    check("midrst_data", data[0], 0);
    check("midrst_we", we[0], 0);
    check("midrst_busy", busy[0], 0);
    check("midrst_done", done[0], 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    nwe = 0;
    nb = 0;
    repeat (20) begin
      @(posedge clk); #1;
      nwe += int'(we[0]);
      nb += int'(busy[0]);
    end
    check("post_rst_we", nwe, 0);
    check("post_rst_busy", nb, 0);
    check("post_rst_writes", wlog.size(), 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
